// File: rtl/apb_slave_pkg.sv
// -----------------------------------------------------------------------------
// apb_slave_pkg
// Shared definitions for the APB register-file slave.
//   - state_e          : FSM encoding (idle / wait-state / response)
//   - DEFAULT_ID_VALUE : constant read back from register 0
//   - clog2()          : register-index width helper
//   - ERR_* constants  : cause of a PSLVERR response
// Optional feature macro used by the slave: APB_PSTRB_EN (byte strobes).
// -----------------------------------------------------------------------------
package apb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

  // Error causes; ERR_NONE means the access is served normally.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_RO    = 2'd3;

  // Smallest r with 2**r >= n; used to size the register index.
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// -----------------------------------------------------------------------------
// apb_reg_bank
// NUM_REGS x 32-bit storage. Register 0 is a hardwired read-only ID value;
// registers 1..NUM_REGS-1 are plain storage cleared by synchronous reset.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   wr_en    in   commit wr_data to register wr_idx at this edge
//   wr_idx   in   register index to write
//   wr_data  in   write data
//   wr_be    in   byte enables (bit n enables wr_data[8n+7:8n])
//   rd_idx   in   register index to read
//   rd_data  out  combinational read data
// -----------------------------------------------------------------------------
module apb_reg_bank
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE,
  parameter int          IDXW     = clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [31:0]     wr_data,
  input  logic [3:0]      wr_be,
  input  logic [IDXW-1:0] rd_idx,
  output logic [31:0]     rd_data
);

  // Index 0 has no storage: it is the constant ID register.
  logic [31:0] regs_q [1:NUM_REGS-1];
  logic [31:0] regs_d [1:NUM_REGS-1];

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_en && (wr_idx == IDXW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) begin
            regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB slave serving a small bank of 32-bit registers behind one PSEL slot
// of the AHB-to-APB bridge, with a fixed number of wait states and PSLVERR
// on misaligned, out-of-range or read-only-write accesses.
// Optional feature: define APB_PSTRB_EN to add the PSTRB byte-strobe port.
// Ports:
//   HCLK     in   system clock, rising edge
//   HRESETn  in   synchronous reset, ACTIVE HIGH despite the name
//   PSEL     in   bridge slave selects; only PSEL[SLOT] is decoded
//   PENABLE  in   APB access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PSTRB    in   byte strobes (APB_PSTRB_EN only)
//   PRDATA   out  read data, valid with PREADY
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  error response, valid with PREADY
// -----------------------------------------------------------------------------
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          SLOT        = 0,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [3:0]  PSTRB,
`endif
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int IDXW = clog2(NUM_REGS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;

  logic        sel;
  logic        unused_psel;
  logic [31:0] chk_addr;
  logic        chk_write;
  logic [1:0]  err_cause;
  logic [31:0] rd_data;
  logic        bank_we;
  logic [3:0]  bank_be;

  assign sel         = PSEL[SLOT];
  assign unused_psel = ^PSEL;

  // The response is registered, so it is computed on the edge that enters
  // ST_RESP. From ST_IDLE (zero wait states) that edge is the setup edge
  // itself, so the live bus is decoded; otherwise the latched copy is used.
  assign chk_addr  = (state_q == ST_IDLE) ? PADDR  : addr_q;
  assign chk_write = (state_q == ST_IDLE) ? PWRITE : write_q;

  always_comb begin
    err_cause = ERR_NONE;
    if (chk_addr[1:0] != 2'b00) begin
      err_cause = ERR_ALIGN;
    end else if (chk_addr[31:IDXW+2] != '0) begin
      err_cause = ERR_RANGE;
    end else if (chk_write && (chk_addr[IDXW+1:2] == '0)) begin
      err_cause = ERR_RO;
    end
  end

`ifdef APB_PSTRB_EN
  logic [3:0] strb_q, strb_d;

  always_comb begin
    strb_d = strb_q;
    if ((state_q == ST_IDLE) && sel && !PENABLE) begin
      strb_d = PSTRB;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      strb_q <= '0;
    end else begin
      strb_q <= strb_d;
    end
  end

  assign bank_be = strb_q;
`else
  assign bank_be = 4'hF;
`endif

  // The write lands at the closing edge of the single response cycle, and
  // only when that response carried no error.
  assign bank_we = (state_q == ST_RESP) && write_q && !pslverr_q;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDXW     (IDXW)
  ) u_bank (
    .clk     (HCLK),
    .rst     (HRESETn),
    .wr_en   (bank_we),
    .wr_idx  (addr_q[IDXW+1:2]),
    .wr_data (wdata_q),
    .wr_be   (bank_be),
    .rd_idx  (chk_addr[IDXW+1:2]),
    .rd_data (rd_data)
  );

  // Transfer FSM: the wait counter runs down in ST_WAIT and the response
  // fields are loaded on the edge that enters ST_RESP.
  always_comb begin
    logic finish;
    finish    = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            finish  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sel && PENABLE) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RESP;
            finish  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      pready_d  = 1'b1;
      pslverr_d = (err_cause != ERR_NONE);
      if (!chk_write && (err_cause == ERR_NONE)) begin
        prdata_d = rd_data;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB responder at the far end of the AHB-to-APB bridge.
- Decodes one slot of the bridge's 3-bit PSEL bus and serves reads and writes to a small bank of 32-bit registers.
- Inserts a parameterised number of wait states via PREADY and flags bad accesses with PSLVERR.
- Serves as the bridge's bench peripheral and as the template for real APB peripherals.

Parameters:
- NUM_REGS, 8: number of 32-bit registers, power of 2, 2..64.
- SLOT, 0: index of the PSEL bit that selects this slave, 0..2.
- WAIT_CYCLES, 0: wait states inserted per transfer, 0..15.
- ID_VALUE, 32'hA5B0_0001: constant returned by register 0 (read-only).

Ports:
- HCLK  in  1  system clock; all logic on the rising edge.
- HRESETn  in  1  synchronous, active-high reset (despite the name).
- PSEL  in  3  bridge slave selects; only bit SLOT is used.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; bits [1:0] and [log2(NUM_REGS)+1:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only when PREADY=1.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Reset (HRESETn=1 at an edge):
  - State goes to ST_IDLE; PRDATA, PREADY and PSLVERR are 0.
  - Registers 1..NUM_REGS-1 clear to 0; the wait counter clears.
  - Reset mid-transfer aborts it; no write is committed.
- sel = PSEL[SLOT].
- ST_IDLE:
  - Setup is sel=1 and PENABLE=0.
  - On setup, latch PADDR, PWRITE and PWDATA, and load cnt=WAIT_CYCLES.
  - If WAIT_CYCLES==0, go to ST_RESP and assert PREADY at the same edge.
  - Otherwise go to ST_WAIT.
  - Setup seen with PENABLE=1 is ignored; stay in ST_IDLE.
- ST_WAIT:
  - Requires sel=1 and PENABLE=1; cnt decrements each cycle.
  - When cnt==1, assert PREADY at the next edge and go to ST_RESP.
- Latency: PREADY is high in access cycle WAIT_CYCLES+1, counted from the first PENABLE=1 cycle.
- ST_RESP (PREADY=1, exactly one cycle):
  - Write with no error: register[idx] <= latched PWDATA at this cycle's closing edge.
  - Read with no error: PRDATA = register[idx] (register 0 reads ID_VALUE).
  - Return to ST_IDLE. PREADY, PRDATA and PSLVERR return to 0 the next cycle.
- Back-to-back: a new setup in the cycle after ST_RESP is accepted normally.
- Error conditions (PSLVERR=1 together with PREADY; no register changes; PRDATA=0):
  - PADDR[1:0] != 0.
  - PADDR above (NUM_REGS*4)-1.
  - A write to register 0.
- Protocol violation: sel or PENABLE dropping in ST_WAIT aborts to ST_IDLE with no write, and PREADY never asserts.
- Address and data are sampled only in the setup cycle; changes during the access phase are ignored.
- Registers other than 0 are plain storage with no side effects.

Optional Feature:
- Macro APB_PSTRB_EN.
- Defined:
  - Adds port PSTRB (in, 4), latched in setup.
  - Writes update only bytes whose strobe bit is 1.
  - PSTRB=0 on a write is a legal no-op with PSLVERR=0.
  - Reads ignore PSTRB.
- Undefined: no PSTRB port; every write updates all 32 bits.

Decomposition:
- Package apb_slave_pkg:
  - State encoding ST_IDLE, ST_WAIT, ST_RESP (2 bits).
  - Default ID_VALUE.
  - Index-width function clog2(NUM_REGS).
  - Error-cause constants ERR_ALIGN, ERR_RANGE, ERR_RO, used for bench coverage.
- Sub-module apb_reg_bank:
  - NUM_REGS x 32 storage with synchronous write enable, optional byte enables and combinational read.
  - Register 0 is hardwired to ID_VALUE.
- The FSM, wait counter and decode stay in the top level.

Test Plan:
- Reset, then WAIT_CYCLES=0: write PADDR=0x4, PWDATA=0xDEADBEEF -> PREADY=1 in the first access cycle, PSLVERR=0. Read 0x4 -> PRDATA=0xDEADBEEF in the first access cycle.
- WAIT_CYCLES=3: read 0x0 -> PREADY low for 3 access cycles, high on the 4th with PRDATA=0xA5B00001.
- Errors:
  - Write 0x0 -> PSLVERR=1, then read 0x0 still returns ID_VALUE.
  - Write 0x6 -> PSLVERR=1.
  - Write 0x20 with NUM_REGS=8 -> PSLVERR=1, and all registers are unchanged.
- Abort: WAIT_CYCLES=2, write 0x8=0x1234, drop PSEL after 1 access cycle -> no PREADY, and a later read of 0x8 returns 0.
- Four back-to-back writes to 0x4..0x10 with no idle cycles -> each completes; read-back matches.
- Reset asserted in ST_WAIT -> PREADY=0 next cycle, registers cleared. With APB_PSTRB_EN: write 0xFFFFFFFF with PSTRB=4'b0101 to a zeroed register -> reads 0x00FF00FF.
